// File: rtl/shader_issue_sched.sv
// Round-robin issue scheduler sharing one shader_core instruction port between NUM_REQ streams.
// Optional saturating issue counter on issue_count when SHADER_SCHED_STATS_EN is defined.
module shader_issue_sched #(
  parameter int                 NUM_REQ   = 4,
  parameter int                 INSTR_W   = 16,
  parameter int                 QUANTUM   = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h6000,
  localparam int                IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [INSTR_W-1:0]         core_instr,
  output logic                       core_issue,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy,
  output logic [15:0]                issue_count
);

  localparam int QW = $clog2(QUANTUM + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state_q;
  logic [IDW-1:0]     owner_q;
  logic [IDW-1:0]     lastOwner_q;
  logic [QW-1:0]      qcnt_q;
  logic [QW-1:0]      qcnt_d;
  logic [INSTR_W-1:0] coreInstr_q;
  logic               coreIssue_q;

  logic [IDW-1:0]     pick_d;
  logic               pickValid;
  logic [IDW-1:0]     scanIdx;
  logic               canIssue;
  logic               handshake;
  logic [INSTR_W-1:0] ownerInstr;

  // Scan upward from the slot after the last owner; power-of-two NUM_REQ makes the wrap free.
  always_comb begin
    pick_d    = '0;
    pickValid = 1'b0;
    scanIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanIdx = lastOwner_q + IDW'(k + 1);
      if (!pickValid && req_valid[scanIdx]) begin
        pickValid = 1'b1;
        pick_d    = scanIdx;
      end
    end
  end

  assign canIssue   = (state_q == ISSUE) && enable && (qcnt_q < QW'(QUANTUM));
  assign handshake  = canIssue && req_valid[owner_q];
  assign ownerInstr = req_instr[owner_q*INSTR_W +: INSTR_W];
  assign qcnt_d     = qcnt_q + QW'(1);

  always_comb begin
    req_ready = '0;
    if (canIssue) begin
      req_ready[owner_q] = 1'b1;
    end
  end

  // Any cycle without a handshake drops a NOP onto the core, since the core writes rd unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      lastOwner_q <= IDW'(NUM_REQ - 1);
      qcnt_q      <= '0;
      coreInstr_q <= NOP_INSTR;
      coreIssue_q <= 1'b0;
    end else begin
      coreInstr_q <= handshake ? ownerInstr : NOP_INSTR;
      coreIssue_q <= handshake;
      case (state_q)
        IDLE: begin
          if (enable && pickValid) begin
            owner_q     <= pick_d;
            lastOwner_q <= pick_d;
            qcnt_q      <= '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (handshake) begin
            qcnt_q <= qcnt_d;
            if (qcnt_d == QW'(QUANTUM)) begin
              state_q <= IDLE;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_instr = coreInstr_q;
  assign core_issue = coreIssue_q;
  assign grant_id   = owner_q;
  assign busy       = (state_q == ISSUE);

`ifdef SHADER_SCHED_STATS_EN
  logic [15:0] issueCount_q;

  // Saturates rather than wraps so a long run never reports a misleadingly small total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issueCount_q <= 16'h0000;
    end else if (handshake && (issueCount_q != 16'hFFFF)) begin
      issueCount_q <= issueCount_q + 16'd1;
    end
  end

  assign issue_count = issueCount_q;
`else
  assign issue_count = 16'h0000;
`endif

endmodule

// File: tb/tb_shader_issue_sched.sv
// Scoreboard bench for shader_issue_sched: directed requester streams, monitor checks issued instructions in order.
module tb_shader_issue_sched;

  localparam int NUM_REQ = 4;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 8;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       enable = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ*INSTR_W-1:0] req_instr = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic [INSTR_W-1:0]         core_instr;
  logic                       core_issue;
  logic [1:0]                 grant_id;
  logic                       busy;
  logic [15:0]                issue_count;

  int testsRun = 0;
  int testsFailed = 0;

  logic [15:0] reqMem [NUM_REQ][DEPTH];
  int          reqHead [NUM_REQ];
  int          reqCnt [NUM_REQ];
  logic [3:0]  activeMask = '0;
  logic [15:0] expQ [$];
  logic [15:0] monExp;

  shader_issue_sched #(
    .NUM_REQ(NUM_REQ), .INSTR_W(INSTR_W), .QUANTUM(4), .NOP_INSTR(16'h6000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_instr(req_instr), .req_ready(req_ready),
    .core_instr(core_instr), .core_issue(core_issue), .grant_id(grant_id),
    .busy(busy), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic driveReq();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (activeMask[i] && (reqHead[i] < reqCnt[i])) begin
        req_valid[i] = 1'b1;
        req_instr[i*INSTR_W +: INSTR_W] = reqMem[i][reqHead[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_instr[i*INSTR_W +: INSTR_W] = 16'h0000;
      end
    end
  endtask

  task automatic loadReq(input int r, input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) reqMem[r][k] = base + 16'(k);
    reqCnt[r]  = n;
    reqHead[r] = 0;
  endtask

  task automatic expectReq(input int r, input int first, input int n);
    for (int k = 0; k < n; k++) expQ.push_back(reqMem[r][first + k]);
  endtask

  // One clock: requesters retire whatever handshook at this edge, then present their next word.
  task automatic applyStimulus();
    logic [NUM_REQ-1:0] hs;
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (hs[i]) reqHead[i]++;
    driveReq();
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    enable = 1'b1;
    activeMask = '0;
    for (int i = 0; i < NUM_REQ; i++) loadReq(i, 0, 16'h0000);
    driveReq();
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int maxCyc);
    int n;
    n = 0;
    while ((expQ.size() != 0) && (n < maxCyc)) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_empty", expQ.size(), 0);
  endtask

  // Monitor: every real issue on the core port must be the next expected instruction.
  always @(negedge clk) begin
    if (rst_n && core_issue) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_issue: got %0h, expected none", core_instr);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("scoreboard_instr", core_instr, monExp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with every requester valid
    rst_n = 1'b0;
    enable = 1'b1;
    activeMask = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) loadReq(i, 1, 16'h0A00);
    driveReq();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_core_instr", core_instr, 16'h6000);
    checkOutput("rst_core_issue", core_issue, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_issue_count", issue_count, 0);

    // Single stream on requester 1
    resetDut();
    reqMem[1][0] = 16'h0071;
    reqMem[1][1] = 16'h2271;
    reqCnt[1] = 2;
    reqHead[1] = 0;
    activeMask = 4'b0010;
    driveReq();
    expectReq(1, 0, 2);
    applyStimulus();
    checkOutput("single_busy", busy, 1);
    checkOutput("single_grant", grant_id, 1);
    checkOutput("single_ready", req_ready, 4'b0010);
    applyStimulus();
    checkOutput("single_issue1", core_issue, 1);
    checkOutput("single_instr1", core_instr, 16'h0071);
    applyStimulus();
    checkOutput("single_instr2", core_instr, 16'h2271);
    applyStimulus();
    checkOutput("single_idle_busy", busy, 0);
    checkOutput("single_idle_issue", core_issue, 0);
    checkOutput("single_idle_nop", core_instr, 16'h6000);
`ifdef SHADER_SCHED_STATS_EN
    checkOutput("single_count", issue_count, 2);
`else
    checkOutput("single_count", issue_count, 0);
`endif
    drain(10);

    // Full contention: strict rotation, 4 issues then one bubble
    resetDut();
    for (int i = 0; i < NUM_REQ; i++) loadReq(i, 5, 16'h1000 | 16'(i << 8));
    activeMask = 4'hF;
    driveReq();
    for (int r = 0; r < NUM_REQ; r++) expectReq(r, 0, 4);
    for (int r = 0; r < NUM_REQ; r++) expectReq(r, 4, 1);
    for (int e = 1; e <= 21; e++) begin
      applyStimulus();
      if (e % 5 == 1) begin
        checkOutput($sformatf("rot_grant_e%0d", e), grant_id, ((e - 1) / 5) % 4);
        checkOutput($sformatf("rot_busy_e%0d", e), busy, 1);
        if (e > 1) checkOutput($sformatf("rot_bubble_e%0d", e), core_issue, 0);
      end
      if (e % 5 == 0) begin
        checkOutput($sformatf("rot_idle_e%0d", e), busy, 0);
        checkOutput($sformatf("rot_last_issue_e%0d", e), core_issue, 1);
      end
    end
    drain(40);

    // Asynchronous reset in the middle of a burst
    resetDut();
    loadReq(0, 4, 16'h3000);
    activeMask = 4'b0001;
    driveReq();
    expectReq(0, 0, 1);
    repeat (3) applyStimulus();
    checkOutput("mid_issue_before", core_issue, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_instr", core_instr, 16'h6000);
    checkOutput("mid_rst_issue", core_issue, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ready", req_ready, 0);
    checkOutput("mid_rst_queue", expQ.size(), 0);

    // Early drop by owner 2 hands over to 3 after one bubble
    resetDut();
    loadReq(2, 2, 16'h4200);
    loadReq(3, 2, 16'h4300);
    activeMask = 4'b1100;
    driveReq();
    expectReq(2, 0, 2);
    expectReq(3, 0, 2);
    applyStimulus();
    checkOutput("drop_grant2", grant_id, 2);
    repeat (2) applyStimulus();
    applyStimulus();
    checkOutput("drop_bubble_busy", busy, 0);
    checkOutput("drop_bubble_issue", core_issue, 0);
    applyStimulus();
    checkOutput("drop_grant3", grant_id, 3);
    checkOutput("drop_busy3", busy, 1);
    drain(20);

    // Enable dropped for 3 cycles mid-burst of requester 0
    resetDut();
    loadReq(0, 6, 16'h5000);
    loadReq(1, 2, 16'h5100);
    activeMask = 4'b0011;
    driveReq();
    expectReq(0, 0, 2);
    expectReq(1, 0, 2);
    expectReq(0, 2, 4);
    repeat (3) applyStimulus();
    enable = 1'b0;
    #1;
    checkOutput("en_off_ready", req_ready, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkOutput($sformatf("en_off_busy_c%0d", c), busy, 0);
      checkOutput($sformatf("en_off_issue_c%0d", c), core_issue, 0);
    end
    enable = 1'b1;
    applyStimulus();
    checkOutput("en_back_grant", grant_id, 1);
    checkOutput("en_back_busy", busy, 1);
    drain(40);

`ifdef SHADER_SCHED_STATS_EN
    // Saturation of the issue counter
    resetDut();
    force dut.issueCount_q = 16'hFFFE;
    #1;
    release dut.issueCount_q;
    checkOutput("stat_preset", issue_count, 16'hFFFE);
    loadReq(0, 3, 16'h7000);
    activeMask = 4'b0001;
    driveReq();
    expectReq(0, 0, 3);
    repeat (2) applyStimulus();
    checkOutput("stat_first", issue_count, 16'hFFFF);
    drain(20);
    checkOutput("stat_saturate", issue_count, 16'hFFFF);
`else
    checkOutput("stat_tied_zero", issue_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
